// File: rtl/buzzer_capture_if.sv
// Host-facing signal bundle of the buzzer front end: raw buttons, round control
// pulses and the latched race result.
interface buzzer_capture_if #(
    parameter int NUM_BTN = 4,
    parameter int TIME_W  = 16,
    parameter int ID_W    = 3
);
    logic [NUM_BTN-1:0] btn_n;
    logic               arm;
    logic               ack;
    logic               armed;
    logic               result_valid;
    logic [ID_W-1:0]    winner_id;
    logic [NUM_BTN-1:0] winner_onehot;
    logic [TIME_W-1:0]  react_ms;
    logic               timeout;

    modport master (
        output btn_n, arm, ack,
        input  armed, result_valid, winner_id, winner_onehot, react_ms, timeout
    );

    modport slave (
        input  btn_n, arm, ack,
        output armed, result_valid, winner_id, winner_onehot, react_ms, timeout
    );
endinterface

// File: rtl/buzzer_capture.sv
// Synchronises and debounces the player buttons, then arbitrates a first-press
// race and holds winner / reaction time until the host acknowledges.
module buzzer_capture #(
    parameter int NUM_BTN      = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TICK_CYC     = 50000,
    parameter int TIME_W       = 16,
    parameter int ID_W         = 3
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    buzzer_capture_if.slave    bus
);
    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_CYC - 1);

    typedef enum logic [1:0] {IDLE, ARMED, RESULT} state_t;

    logic [NUM_BTN-1:0] sync1, sync2, level, level_d, press;
    logic [DB_W-1:0]    db_cnt [NUM_BTN];

    state_t             state, state_next;
    logic [TK_W-1:0]    tick_cnt, tick_next;
    logic [TIME_W-1:0]  react, react_next;
    logic [ID_W-1:0]    win_q, win_next, win_id;
    logic [NUM_BTN-1:0] oh_q, oh_next, win_oh;
    logic               to_q, to_next;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            level   <= '1;
            level_d <= '1;
            for (int unsigned i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= bus.btn_n;
            sync2   <= sync1;
            level_d <= level;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Only a debounced 1->0 transition is an event; releases are silent.
    assign press  = level_d & ~level;
    assign win_oh = press & (~press + NUM_BTN'(1));

    always_comb begin
        win_id = '0;
        for (int unsigned i = NUM_BTN; i > 0; i--) begin
            if (press[i-1]) win_id = ID_W'(i - 1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            react    <= '0;
            win_q    <= '0;
            oh_q     <= '0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            react    <= react_next;
            win_q    <= win_next;
            oh_q     <= oh_next;
            to_q     <= to_next;
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        react_next = react;
        win_next   = win_q;
        oh_next    = oh_q;
        to_next    = to_q;
        unique case (state)
            IDLE: begin
                if (bus.arm) begin
                    state_next = ARMED;
                    tick_next  = '0;
                    react_next = '0;
                    win_next   = '0;
                    oh_next    = '0;
                    to_next    = 1'b0;
                end
            end
            ARMED: begin
                // Priority: press, then re-arm, then timer (with saturation timeout).
                if (|press) begin
                    state_next = RESULT;
                    win_next   = win_id;
                    oh_next    = win_oh;
                    to_next    = 1'b0;
                end else if (bus.arm) begin
                    tick_next  = '0;
                    react_next = '0;
                end else if (tick_cnt == TK_MAX) begin
                    tick_next = '0;
                    if (react == '1) begin
                        state_next = RESULT;
                        to_next    = 1'b1;
                        win_next   = '0;
                        oh_next    = '0;
                    end else begin
                        react_next = react + TIME_W'(1);
                    end
                end else begin
                    tick_next = tick_cnt + TK_W'(1);
                end
            end
            RESULT: begin
                if (bus.ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.armed         = (state == ARMED);
    assign bus.result_valid  = (state == RESULT);
    assign bus.winner_id     = win_q;
    assign bus.winner_onehot = oh_q;
    assign bus.react_ms      = react;
    assign bus.timeout       = to_q;
endmodule

// File: tb/tb_buzzer_capture.sv
// Bench for buzzer_capture: directed scenarios plus a randomized race run
// checked against a cycle-stepped behavioural model.
module tb_buzzer_capture;
    localparam int NB   = 4;
    localparam int DB   = 4;
    localparam int TK   = 10;
    localparam int TW   = 4;
    localparam int IW   = 3;
    localparam int MAXR = (1 << TW) - 1;

    typedef enum int {M_IDLE, M_ARMED, M_RESULT} mstate_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buzzer_capture_if #(.NUM_BTN(NB), .TIME_W(TW), .ID_W(IW)) bus ();

    buzzer_capture #(
        .NUM_BTN(NB), .DEBOUNCE_CYC(DB), .TICK_CYC(TK), .TIME_W(TW), .ID_W(IW)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: sync = raw delayed two samples; level flips once DB
    // consecutive samples disagree with it; react = elapsed clocks / TK.
    int          m_n = 0;
    logic [NB-1:0] m_p1, m_p2, m_lvl, m_press;
    int          m_last_eq [NB];
    mstate_t     m_state = M_IDLE;
    int          m_cyc, m_react, m_win;
    logic [NB-1:0] m_oh;
    logic        m_to;

    task automatic model_step();
        logic [NB-1:0] pr, nl;
        m_n++;
        if (rst) begin
            m_p1 = '1; m_p2 = '1; m_lvl = '1; m_press = '0;
            for (int i = 0; i < NB; i++) m_last_eq[i] = m_n;
            m_state = M_IDLE; m_cyc = 0; m_react = 0; m_win = 0; m_oh = '0; m_to = 1'b0;
            return;
        end
        pr = m_press;
        case (m_state)
            M_IDLE: if (bus.arm) begin
                m_state = M_ARMED; m_cyc = 0; m_react = 0; m_win = 0; m_oh = '0; m_to = 1'b0;
            end
            M_ARMED: begin
                if (pr != '0) begin
                    for (int i = NB - 1; i >= 0; i--) if (pr[i]) m_win = i;
                    m_oh = NB'(1) << m_win;
                    m_to = 1'b0;
                    m_state = M_RESULT;
                end else if (bus.arm) begin
                    m_cyc = 0; m_react = 0;
                end else begin
                    m_cyc++;
                    if (m_cyc / TK > MAXR) begin
                        m_state = M_RESULT; m_to = 1'b1; m_react = MAXR; m_win = 0; m_oh = '0;
                    end else begin
                        m_react = m_cyc / TK;
                    end
                end
            end
            default: if (bus.ack) m_state = M_IDLE;
        endcase
        nl = m_lvl;
        for (int i = 0; i < NB; i++) begin
            if (m_p2[i] == m_lvl[i]) m_last_eq[i] = m_n;
            else if (m_n - m_last_eq[i] >= DB) begin
                nl[i] = m_p2[i];
                m_last_eq[i] = m_n;
            end
        end
        m_press = m_lvl & ~nl;
        m_lvl = nl;
        m_p2 = m_p1;
        m_p1 = bus.btn_n;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < limit && !ok) begin
            tick();
            n++;
            if (bus.result_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%0b exp=0", bus.armed); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.result_valid); end
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", bus.timeout); end
        checks++; if (bus.react_ms !== '0) begin failures++; $display("FAIL reset_react got=%0d exp=0", bus.react_ms); end
        checks++; if (bus.winner_onehot !== '0) begin failures++; $display("FAIL reset_onehot got=%b exp=0000", bus.winner_onehot); end
        checks++; if (bus.winner_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.winner_id); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_press();
        int n; bit ok;
        pulse_arm();
        repeat (25) tick();
        bus.btn_n[2] = 1'b0;
        wait_valid(40, n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL press_valid got=timeout exp=result_valid"); end
        checks++; if (n != 2 + DB + 1) begin failures++; $display("FAIL press_latency got=%0d exp=%0d", n, 2 + DB + 1); end
        checks++; if (bus.winner_id !== 3'd2) begin failures++; $display("FAIL press_id got=%0d exp=2", bus.winner_id); end
        checks++; if (bus.winner_onehot !== 4'b0100) begin failures++; $display("FAIL press_onehot got=%b exp=0100", bus.winner_onehot); end
        checks++; if (bus.react_ms !== 4'd3) begin failures++; $display("FAIL press_react got=%0d exp=3", bus.react_ms); end
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL press_timeout got=%0b exp=0", bus.timeout); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (bus.result_valid !== 1'b1 || bus.winner_id !== 3'd2 || bus.react_ms !== 4'd3 || bus.winner_onehot !== 4'b0100) begin
                failures++; $display("FAIL hold_result cyc=%0d got v=%0b id=%0d t=%0d oh=%b exp v=1 id=2 t=3 oh=0100",
                                     i, bus.result_valid, bus.winner_id, bus.react_ms, bus.winner_onehot);
            end
        end
        pulse_ack();
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL ack_valid got=%0b exp=0", bus.result_valid); end
        checks++; if (bus.react_ms !== 4'd3) begin failures++; $display("FAIL ack_keeps_react got=%0d exp=3", bus.react_ms); end
        bus.btn_n = '1;
        repeat (DB + 4) tick();
    endtask

    task automatic test_tie();
        int n; bit ok;
        pulse_arm();
        repeat (7) tick();
        bus.btn_n = 4'b0101;
        wait_valid(40, n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tie_valid got=timeout exp=result_valid"); end
        checks++; if (bus.winner_id !== 3'd1) begin failures++; $display("FAIL tie_id got=%0d exp=1", bus.winner_id); end
        checks++; if (bus.winner_onehot !== 4'b0010) begin failures++; $display("FAIL tie_onehot got=%b exp=0010", bus.winner_onehot); end
        pulse_ack();
        bus.btn_n = '1;
        repeat (DB + 4) tick();
    endtask

    task automatic test_glitch();
        int n; bit ok;
        pulse_arm();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 6; k++) begin
                bus.btn_n[0] = (k < 3) ? 1'b0 : 1'b1;
                tick();
                checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL glitch_no_result g=%0d k=%0d got=%0b exp=0", g, k, bus.result_valid); end
            end
        end
        bus.btn_n[0] = 1'b0;
        wait_valid(40, n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL glitch_hold_valid got=timeout exp=result_valid"); end
        checks++; if (bus.winner_id !== 3'd0 || bus.winner_onehot !== 4'b0001) begin
            failures++; $display("FAIL glitch_winner got id=%0d oh=%b exp id=0 oh=0001", bus.winner_id, bus.winner_onehot);
        end
        checks++; if (bus.react_ms !== TW'(m_react)) begin failures++; $display("FAIL glitch_react got=%0d exp=%0d", bus.react_ms, m_react); end
        pulse_ack();
        bus.btn_n = '1;
        repeat (DB + 4) tick();
    endtask

    task automatic test_timeout();
        int n; bit ok;
        pulse_arm();
        wait_valid(200, n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_valid got=no_result exp=result_valid"); end
        checks++; if (n != (MAXR + 1) * TK) begin failures++; $display("FAIL to_cycles got=%0d exp=%0d", n, (MAXR + 1) * TK); end
        checks++; if (bus.timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%0b exp=1", bus.timeout); end
        checks++; if (bus.react_ms !== TW'(MAXR)) begin failures++; $display("FAIL to_react got=%0d exp=%0d", bus.react_ms, MAXR); end
        checks++; if (bus.winner_onehot !== '0 || bus.winner_id !== '0) begin
            failures++; $display("FAIL to_winner got id=%0d oh=%b exp id=0 oh=0000", bus.winner_id, bus.winner_onehot);
        end
        pulse_arm();
        checks++; if (bus.result_valid !== 1'b1 || bus.armed !== 1'b0) begin
            failures++; $display("FAIL arm_in_result got v=%0b a=%0b exp v=1 a=0", bus.result_valid, bus.armed);
        end
        bus.arm = 1'b1; bus.ack = 1'b1; tick(); bus.arm = 1'b0; bus.ack = 1'b0;
        checks++; if (bus.result_valid !== 1'b0 || bus.armed !== 1'b0) begin
            failures++; $display("FAIL arm_with_ack got v=%0b a=%0b exp v=0 a=0", bus.result_valid, bus.armed);
        end
        tick();
        checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL arm_with_ack_idle got=%0b exp=0", bus.armed); end
    endtask

    task automatic test_held_across_arm();
        int n; bit ok;
        bus.btn_n[3] = 1'b0;
        repeat (DB + 6) tick();
        checks++; if (bus.result_valid !== 1'b0 || bus.armed !== 1'b0) begin
            failures++; $display("FAIL idle_press_ignored got v=%0b a=%0b exp v=0 a=0", bus.result_valid, bus.armed);
        end
        pulse_arm();
        repeat (20) tick();
        checks++; if (bus.result_valid !== 1'b0 || bus.armed !== 1'b1) begin
            failures++; $display("FAIL held_no_win got v=%0b a=%0b exp v=0 a=1", bus.result_valid, bus.armed);
        end
        bus.btn_n[3] = 1'b1;
        repeat (DB + 4) tick();
        bus.btn_n[3] = 1'b0;
        wait_valid(40, n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL repress_valid got=timeout exp=result_valid"); end
        checks++; if (bus.winner_id !== 3'd3 || bus.winner_onehot !== 4'b1000) begin
            failures++; $display("FAIL repress_winner got id=%0d oh=%b exp id=3 oh=1000", bus.winner_id, bus.winner_onehot);
        end
        pulse_ack();
        bus.btn_n = '1;
        repeat (DB + 4) tick();
    endtask

    task automatic test_reset_mid();
        pulse_arm();
        repeat (12) tick();
        bus.btn_n[3] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.armed !== 1'b0 || bus.result_valid !== 1'b0 || bus.react_ms !== '0) begin
            failures++; $display("FAIL reset_mid got a=%0b v=%0b t=%0d exp a=0 v=0 t=0", bus.armed, bus.result_valid, bus.react_ms);
        end
        rst = 1'b0;
        for (int i = 0; i < DB + 10; i++) begin
            tick();
            checks++; if (bus.result_valid !== 1'b0 || bus.armed !== 1'b0) begin
                failures++; $display("FAIL reset_mid_quiet cyc=%0d got v=%0b a=%0b exp v=0 a=0", i, bus.result_valid, bus.armed);
            end
        end
        bus.btn_n = '1;
        repeat (DB + 4) tick();
    endtask

    task automatic test_random();
        int phase = 3, c = 0, t_press = 0, hold_left = 0, cool_left = 0, rounds = 0, glen = 0, gbit = 0;
        logic [NB-1:0] mask = '1;
        for (int cyc = 0; cyc < 8000 && rounds < 12; cyc++) begin
            bus.arm = 1'b0;
            bus.ack = 1'b0;
            case (phase)
                3: begin
                    bus.arm = 1'b1;
                    bus.btn_n = '1;
                    t_press = $urandom_range(0, 180);
                    mask = NB'($urandom_range(1, (1 << NB) - 1));
                    c = 0; glen = 0;
                    phase = 0;
                end
                0: begin
                    if (c >= t_press) begin
                        bus.btn_n = ~mask;
                    end else begin
                        if (glen == 0 && $urandom_range(0, 9) == 0) begin
                            glen = $urandom_range(1, DB - 1);
                            gbit = $urandom_range(0, NB - 1);
                        end
                        bus.btn_n = '1;
                        if (glen > 0) begin bus.btn_n[gbit] = 1'b0; glen--; end
                    end
                    bus.arm = ($urandom_range(0, 149) == 0);
                    c++;
                end
                1: begin
                    bus.arm = $urandom_range(0, 1);
                    if (hold_left == 0) begin
                        bus.ack = 1'b1;
                        phase = 2;
                        cool_left = DB + 4;
                    end else begin
                        hold_left--;
                    end
                end
                default: begin
                    bus.btn_n = '1;
                    if (cool_left == 0) begin phase = 3; rounds++; end
                    else cool_left--;
                end
            endcase
            tick();
            checks++; if (bus.armed !== (m_state == M_ARMED) || bus.result_valid !== (m_state == M_RESULT)) begin
                failures++; $display("FAIL rnd_state cyc=%0d got a=%0b v=%0b exp a=%0b v=%0b", cyc, bus.armed, bus.result_valid,
                                     m_state == M_ARMED, m_state == M_RESULT);
            end
            checks++; if (bus.winner_id !== IW'(m_win) || bus.winner_onehot !== m_oh) begin
                failures++; $display("FAIL rnd_winner cyc=%0d got id=%0d oh=%b exp id=%0d oh=%b", cyc, bus.winner_id, bus.winner_onehot, m_win, m_oh);
            end
            checks++; if (bus.react_ms !== TW'(m_react) || bus.timeout !== m_to) begin
                failures++; $display("FAIL rnd_react cyc=%0d got t=%0d to=%0b exp t=%0d to=%0b", cyc, bus.react_ms, bus.timeout, m_react, m_to);
            end
            if (phase == 0 && m_state == M_RESULT) begin
                phase = 1;
                hold_left = $urandom_range(0, 4);
            end
        end
        checks++; if (rounds < 12) begin failures++; $display("FAIL rnd_rounds got=%0d exp=12", rounds); end
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_n = '1;
        bus.arm = 1'b0;
        bus.ack = 1'b0;
        test_reset();
        test_first_press();
        test_tie();
        test_glitch();
        test_timeout();
        test_held_across_arm();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
